rr_stage: RTL

Register-read stage of the pipelined 16-bit core: sits directly downstream of the ID/RR pipeline register and feeds the execute stage. Reads the 8×16 register file, forwards in-flight results from EX/MEM/WB, detects load-use hazards (stalling upstream and inserting a bubble), and registers operands, immediate and control into the RR/EX boundary. Branch/jump flushes from EX squash the RR instruction.

---
 rtl/rr_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rr_stage.sv
// Register-read stage: 8x16 register file, EX/MEM/WB operand forwarding,
// load-use stall with bubble insertion, and the RR/EX pipeline register.
module rr_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_rr,
  input  logic [CTRL_W-1:0] ctrl_rr,
  input  logic              reg_wr_en_rr,
  input  logic              mem_write_en_rr,
  input  logic              is_load_rr,
  input  logic [2:0]        instr_ra_rr,
  input  logic [2:0]        instr_rb_rr,
  input  logic [2:0]        instr_rc_rr,
  input  logic              rd_ra_en,
  input  logic              rd_rb_en,
  input  logic [5:0]        instr_imm6_rr,
  input  logic [8:0]        instr_imm9_rr,
  input  logic [1:0]        imm_sel,
  input  logic [15:0]       pc_out_rr,
  input  logic [15:0]       pc_inc_rr,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_dest,
  input  logic [15:0]       ex_result,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_dest,
  input  logic [15:0]       mem_result,
  input  logic              wb_wr_en,
  input  logic [2:0]        wb_dest,
  input  logic [15:0]       wb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              valid_ex,
  output logic              reg_wr_en_ex,
  output logic              mem_write_en_ex,
  output logic              is_load_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic [15:0]       ra_val_ex,
  output logic [15:0]       rb_val_ex,
  output logic [15:0]       imm_ex,
  output logic [15:0]       pc_out_ex,
  output logic [15:0]       pc_inc_ex,
  output logic [2:0]        instr_rc_ex
);

  logic [15:0] regfile [8];
  logic [15:0] ra_sel, rb_sel, imm_sel_val;
  logic        ex_fwd, hz, bubble;

  // A load's data does not exist until MEM, so EX forwarding excludes loads.
  assign ex_fwd = ex_wr_en && !ex_is_load;

  assign hz = valid_rr && ex_wr_en && ex_is_load &&
              ((rd_ra_en && ex_dest == instr_ra_rr) ||
               (rd_rb_en && ex_dest == instr_rb_rr));

  assign stall_out = rst_n && hz && !flush;
  assign bubble    = flush || hz || !valid_rr;

  // NOTE: every always_comb output gets a default first so no latch is inferred;
  // later assignments override earlier ones, giving EX > MEM > WB > regfile.
  always_comb begin
    ra_sel = regfile[instr_ra_rr];
    if (wb_wr_en  && wb_dest  == instr_ra_rr) ra_sel = wb_data;
    if (mem_wr_en && mem_dest == instr_ra_rr) ra_sel = mem_result;
    if (ex_fwd    && ex_dest  == instr_ra_rr) ra_sel = ex_result;

    rb_sel = regfile[instr_rb_rr];
    if (wb_wr_en  && wb_dest  == instr_rb_rr) rb_sel = wb_data;
    if (mem_wr_en && mem_dest == instr_rb_rr) rb_sel = mem_result;
    if (ex_fwd    && ex_dest  == instr_rb_rr) rb_sel = ex_result;
  end

  always_comb begin
    imm_sel_val = 16'h0000;
    unique case (imm_sel)
      2'b00: imm_sel_val = {{10{instr_imm6_rr[5]}}, instr_imm6_rr};
      2'b01: imm_sel_val = {{7{instr_imm9_rr[8]}}, instr_imm9_rr};
      2'b10: imm_sel_val = {instr_imm9_rr, 7'b0};
      2'b11: imm_sel_val = 16'h0000;
    endcase
  end

  // NOTE: the register file is a real storage array that must read as zero
  // after reset, so it is cleared here; the write port ignores stall/flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regfile[i] <= 16'h0000;
    end else if (wb_wr_en) begin
      regfile[wb_dest] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      valid_ex        <= 1'b0;
      reg_wr_en_ex    <= 1'b0;
      mem_write_en_ex <= 1'b0;
      is_load_ex      <= 1'b0;
      ctrl_ex         <= '0;
      ra_val_ex       <= 16'h0000;
      rb_val_ex       <= 16'h0000;
      imm_ex          <= 16'h0000;
      pc_out_ex       <= 16'h0000;
      pc_inc_ex       <= 16'h0000;
      instr_rc_ex     <= 3'd0;
    end else begin
      valid_ex        <= 1'b1;
      reg_wr_en_ex    <= reg_wr_en_rr;
      mem_write_en_ex <= mem_write_en_rr;
      is_load_ex      <= is_load_rr;
      ctrl_ex         <= ctrl_rr;
      ra_val_ex       <= ra_sel;
      rb_val_ex       <= rb_sel;
      imm_ex          <= imm_sel_val;
      pc_out_ex       <= pc_out_rr;
      pc_inc_ex       <= pc_inc_rr;
      instr_rc_ex     <= instr_rc_rr;
    end
  end

endmodule
